// File: rtl/lfsr_pkg.sv
// Shared LFSR definitions: the step function used by generator and checker,
// plus the checker FSM state encoding.
package lfsr_pkg;

    // Widest LFSR the shared step function supports; callers zero-extend and truncate.
    localparam int LFSR_MAX_W = 64;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } lfsr_chk_state_t;

    // Low N bits of the result equal {q[N-2:0], ^(q & mask)} when q/mask are zero-extended.
    function automatic logic [LFSR_MAX_W-1:0] lfsr_step(
        input logic [LFSR_MAX_W-1:0] q,
        input logic [LFSR_MAX_W-1:0] mask
    );
        lfsr_step = {q[LFSR_MAX_W-2:0], ^(q & mask)};
    endfunction

endpackage

// File: rtl/lfsr_checker_if.sv
// Sample stream into the checker together with its status outputs.
interface lfsr_checker_if #(
    parameter int N     = 4,
    parameter int CNT_W = 16
);
    logic             valid;
    logic [N-1:0]     d;
    logic [N-1:0]     mask;
    logic             clr_cnt;
    logic             locked;
    logic             err;
    logic [CNT_W-1:0] err_cnt;

    modport master (
        output valid, d, mask, clr_cnt,
        input  locked, err, err_cnt
    );

    modport slave (
        input  valid, d, mask, clr_cnt,
        output locked, err, err_cnt
    );
endinterface

// File: rtl/sat_counter.sv
// Saturating event counter; a clear wins over an increment but still
// records an event arriving in the same cycle.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);
    logic [W-1:0] cnt_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_reg <= '0;
        end else if (clr) begin
            cnt_reg <= inc ? W'(1) : '0;
        end else if (inc && (cnt_reg != '1)) begin
            cnt_reg <= cnt_reg + W'(1);
        end
    end

    assign cnt = cnt_reg;
endmodule

// File: rtl/lfsr_checker.sv
// Receive-side LFSR checker: self-seeds from incoming words, locks after a run
// of correct predictions, then flywheels and counts mismatches.
module lfsr_checker
    import lfsr_pkg::*;
#(
    parameter int N           = 4,
    parameter int LOCK_CNT    = 3,
    parameter int LOSS_THRESH = 4,
    parameter int CNT_W       = 16
) (
    input  logic          clk,
    input  logic          rst,
    lfsr_checker_if.slave bus
);
    localparam int RUN_W  = $clog2(LOCK_CNT + 1);
    localparam int MISS_W = $clog2(LOSS_THRESH + 1);

    lfsr_chk_state_t state_reg, state_next;
    logic [N-1:0]      pred_reg, pred_next;
    logic [RUN_W-1:0]  run_reg, run_next;
    logic [MISS_W-1:0] miss_reg, miss_next;
    logic              locked_reg, locked_next;
    logic              err_reg, err_next;

    logic [N-1:0]      step_d;
    logic [N-1:0]      step_pred;
    logic [RUN_W-1:0]  run_inc;
    logic [MISS_W-1:0] miss_inc;
    logic              match;

    assign step_d    = N'(lfsr_step(LFSR_MAX_W'(bus.d), LFSR_MAX_W'(bus.mask)));
    assign step_pred = N'(lfsr_step(LFSR_MAX_W'(pred_reg), LFSR_MAX_W'(bus.mask)));
    assign run_inc   = run_reg + RUN_W'(1);
    assign miss_inc  = miss_reg + MISS_W'(1);
    assign match     = (bus.d == pred_reg);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg  <= HUNT;
            pred_reg   <= '0;
            run_reg    <= '0;
            miss_reg   <= '0;
            locked_reg <= 1'b0;
            err_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            pred_reg   <= pred_next;
            run_reg    <= run_next;
            miss_reg   <= miss_next;
            locked_reg <= locked_next;
            err_reg    <= err_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        pred_next  = pred_reg;
        run_next   = run_reg;
        miss_next  = miss_reg;
        err_next   = 1'b0;

        if (bus.valid) begin
            case (state_reg)
                HUNT: begin
                    // The all-zero word is the LFSR lockup state and cannot seed a prediction.
                    if (bus.d != '0) begin
                        pred_next  = step_d;
                        run_next   = '0;
                        state_next = VERIFY;
                    end
                end
                VERIFY: begin
                    pred_next = step_d;
                    if (match) begin
                        run_next = run_inc;
                        if (run_inc == RUN_W'(LOCK_CNT)) begin
                            miss_next  = '0;
                            state_next = LOCKED;
                        end
                    end else begin
                        run_next = '0;
                        if (bus.d == '0) begin
                            state_next = HUNT;
                        end
                    end
                end
                LOCKED: begin
                    if (match) begin
                        miss_next = '0;
                        pred_next = step_d;
                    end else begin
                        // Flywheel on our own prediction so corrupt data never reseeds us.
                        pred_next = step_pred;
                        err_next  = 1'b1;
                        miss_next = miss_inc;
                        if (miss_inc == MISS_W'(LOSS_THRESH)) begin
                            state_next = HUNT;
                        end
                    end
                end
                default: state_next = HUNT;
            endcase
        end

        locked_next = (state_next == LOCKED);
    end

    sat_counter #(
        .W(CNT_W)
    ) u_err_cnt (
        .clk (clk),
        .rst (rst),
        .inc (err_next),
        .clr (bus.clr_cnt),
        .cnt (bus.err_cnt)
    );

    assign bus.locked = locked_reg;
    assign bus.err    = err_reg;
endmodule

// File: tb/tb_lfsr_checker.sv
// Scoreboard bench: stimulus pushes hand-computed expectations per sample; a
// monitor pops and compares half a cycle after each sampling edge.
module tb_lfsr_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       drv_valid;
    logic       drv_clr;
    logic       drv_chk;
    logic [3:0] drv_d;

    lfsr_checker_if #(.N(4), .CNT_W(16)) bus_a ();
    lfsr_checker_if #(.N(4), .CNT_W(2))  bus_b ();

    assign bus_a.valid   = drv_valid;
    assign bus_a.d       = drv_d;
    assign bus_a.mask    = 4'b0110;
    assign bus_a.clr_cnt = drv_clr;
    assign bus_b.valid   = drv_valid;
    assign bus_b.d       = drv_d;
    assign bus_b.mask    = 4'b0110;
    assign bus_b.clr_cnt = drv_clr;

    lfsr_checker #(.N(4), .LOCK_CNT(3), .LOSS_THRESH(4), .CNT_W(16)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a.slave)
    );

    lfsr_checker #(.N(4), .LOCK_CNT(3), .LOSS_THRESH(4), .CNT_W(2)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b.slave)
    );

    typedef struct {
        logic [3:0]  d;
        logic        locked;
        logic        err;
        logic [15:0] cnt_a;
        logic [1:0]  cnt_b;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   txn    = 0;
    int   idx    = 0;

    // Reference sequence for mask 0110 seeded with 0101 (period 7).
    logic [3:0] seq [7] = '{4'b0101, 4'b1011, 4'b0111, 4'b1110, 4'b1100, 4'b1001, 4'b0010};

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic drive(input logic [3:0] d, input logic v, input logic clr, input logic chk,
                         input logic e_locked, input logic e_err,
                         input int e_cnt_a, input int e_cnt_b);
        exp_t e;
        @(negedge clk);
        drv_d     = d;
        drv_valid = v;
        drv_clr   = clr;
        drv_chk   = chk;
        if (chk) begin
            e.d      = d;
            e.locked = e_locked;
            e.err    = e_err;
            e.cnt_a  = 16'(e_cnt_a);
            e.cnt_b  = 2'(e_cnt_b);
            exp_q.push_back(e);
        end
    endtask

    task automatic good(input logic e_locked, input int e_cnt_a, input int e_cnt_b);
        drive(seq[idx], 1'b1, 1'b0, 1'b1, e_locked, 1'b0, e_cnt_a, e_cnt_b);
        idx = (idx + 1) % 7;
    endtask

    task automatic bad(input logic e_locked, input int e_cnt_a, input int e_cnt_b);
        drive(seq[idx] ^ 4'b0001, 1'b1, 1'b0, 1'b1, e_locked, 1'b1, e_cnt_a, e_cnt_b);
        idx = (idx + 1) % 7;
    endtask

    task automatic gap(input logic e_locked, input int e_cnt_a, input int e_cnt_b);
        drive(4'b1111, 1'b0, 1'b0, 1'b1, e_locked, 1'b0, e_cnt_a, e_cnt_b);
    endtask

    task automatic idle();
        drive(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    endtask

    // Monitor: every checked sample yields one comparison set on the following negedge.
    initial begin
        logic v;
        exp_t e;
        forever begin
            @(posedge clk);
            v = drv_chk;
            @(negedge clk);
            if (v) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL queue_empty: got 0 entries, required at least 1");
                end else begin
                    e = exp_q.pop_front();
                    txn++;
                    $display("txn %0d d=%b locked=%0d err=%0d cnt_a=%0d cnt_b=%0d", txn, e.d,
                             bus_a.locked, bus_a.err, bus_a.err_cnt, bus_b.err_cnt);
                    check("locked", int'(bus_a.locked), int'(e.locked));
                    check("err", int'(bus_a.err), int'(e.err));
                    check("err_cnt", int'(bus_a.err_cnt), int'(e.cnt_a));
                    check("err_cnt_sat", int'(bus_b.err_cnt), int'(e.cnt_b));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b0;
        drv_valid = 1'b0;
        drv_clr   = 1'b0;
        drv_chk   = 1'b0;
        drv_d     = 4'b0000;
        repeat (2) @(negedge clk);
        check("reset_locked", int'(bus_a.locked), 0);
        check("reset_err", int'(bus_a.err), 0);
        check("reset_err_cnt", int'(bus_a.err_cnt), 0);
        @(negedge clk);
        rst = 1'b1;

        // Clean lock: locked after the 4th sample, no errors over 50 samples.
        for (int k = 1; k <= 50; k++) good(k >= 4, 0, 0);

        // Single error in place of 1100, then the true sequence resumes.
        while (seq[idx] != 4'b1100) good(1'b1, 0, 0);
        drive(4'b1101, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1, 1);
        idx = (idx + 1) % 7;
        repeat (3) good(1'b1, 1, 1);

        // Clear, then four consecutive mismatches drop lock; relock after 4 samples.
        drive(seq[idx], 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 0, 0);
        idx = (idx + 1) % 7;
        bad(1'b1, 1, 1);
        bad(1'b1, 2, 2);
        bad(1'b1, 3, 3);
        bad(1'b0, 4, 3);
        good(1'b0, 4, 3);
        good(1'b0, 4, 3);
        good(1'b0, 4, 3);
        good(1'b1, 4, 3);
        good(1'b1, 4, 3);

        // Lockup word, then the sequence with valid gaps.
        idle();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (5) drive(4'b0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
        idx = 0;
        for (int i = 0; i < 6; i++) begin
            good(i >= 3, 0, 0);
            gap(i >= 3, 0, 0);
        end

        // Isolated errors saturate the 2-bit counter; clear coinciding with an error leaves 1.
        bad(1'b1, 1, 1);
        good(1'b1, 1, 1);
        bad(1'b1, 2, 2);
        good(1'b1, 2, 2);
        bad(1'b1, 3, 3);
        good(1'b1, 3, 3);
        bad(1'b1, 4, 3);
        good(1'b1, 4, 3);
        drive(seq[idx] ^ 4'b0001, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1, 1);
        idx = (idx + 1) % 7;
        good(1'b1, 1, 1);

        // Asynchronous reset between edges while err is high.
        drive(seq[idx] ^ 4'b0001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        @(posedge clk);
        #1;
        check("pre_rst_err", int'(bus_a.err), 1);
        check("pre_rst_err_cnt", int'(bus_a.err_cnt), 2);
        check("pre_rst_locked", int'(bus_a.locked), 1);
        #2;
        rst = 1'b0;
        #1;
        check("async_rst_locked", int'(bus_a.locked), 0);
        check("async_rst_err", int'(bus_a.err), 0);
        check("async_rst_err_cnt", int'(bus_a.err_cnt), 0);
        check("async_rst_err_cnt_sat", int'(bus_b.err_cnt), 0);
        @(negedge clk);
        drv_valid = 1'b0;
        drv_chk   = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        idx = 0;
        good(1'b0, 0, 0);
        good(1'b0, 0, 0);
        good(1'b0, 0, 0);
        good(1'b1, 0, 0);
        idle();
        idle();
        check("queue_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lfsr_checker.md
# lfsr_checker

Receive-side companion to the `lfsr` pattern generator: samples the N-bit word stream produced by a generator with the same `mask` and decides whether it is a valid LFSR sequence. Self-synchronises from the incoming data, declares lock after a run of correct predictions, and then counts mismatches. Sits at the sink end of any PRBS/LFSR test path in the design, such as a loopback of a bus or a memory test.

## Interface
- `N`, 4: LFSR width; must match the generator.
- `LOCK_CNT`, 3: consecutive correct predictions required to declare lock (≥1).
- `LOSS_THRESH`, 4: consecutive mismatches while locked that drop lock (≥1).
- `CNT_W`, 16: error counter width.

- `clk` in 1: rising-edge clock.
- `rst` in 1: **asynchronous, active-low** reset.
- `valid` in 1: `d` carries a sample this cycle.
- `d` in N: received LFSR word.
- `mask` in N: feedback tap mask. Quasi-static.
- `clr_cnt` in 1: synchronous clear of `err_cnt`.
- `locked` out 1: checker is in LOCKED.
- `err` out 1: one-cycle pulse for each mismatch while LOCKED.
- `err_cnt` out CNT_W: saturating mismatch count.

## Operation
- The step function is shared with `lfsr`:
  - `fb = ^(q & mask)`
  - `next = {q[N-2:0], fb}`
- Internal state:
  - `pred` (N bits): predicted next word.
  - `run` counter: counts up to LOCK_CNT.
  - `miss` counter: counts up to LOSS_THRESH.
  - FSM with states HUNT, VERIFY, LOCKED.
- When `valid`=0, no state, `pred` or counter changes occur, and `err`=0.
- HUNT, on `valid`:
  - If `d`≠0: `pred`←step(`d`), `run`←0, go to VERIFY.
  - If `d`=0 (the lockup word): stay in HUNT.
- VERIFY, on `valid`:
  - On a match (`d`==`pred`): `pred`←step(`d`), `run`←`run`+1. When `run`+1==LOCK_CNT, go to LOCKED with `miss`←0.
  - On a mismatch: reseed with `pred`←step(`d`) and `run`←0, and stay in VERIFY. If `d`=0, go to HUNT instead.
- LOCKED, on `valid`:
  - On a match: `miss`←0, `pred`←step(`d`).
  - On a mismatch: `pred`←step(`pred`) (flywheel, no reseed from bad data), `err` pulses, `err_cnt` increments, `miss`←`miss`+1.
  - When `miss`+1==LOSS_THRESH, go to HUNT. `err` still pulses for that final mismatch.
- `err_cnt`:
  - Saturates at all-ones and never wraps.
  - Counts only in LOCKED.
  - `clr_cnt` has priority: with `clr_cnt`=1, `err_cnt`←1 if an error is registered in the same cycle, otherwise 0.
- `mask` changes are legal only in HUNT. A change in any other state is handled as ordinary data mismatches, with no special detection.
- Reset mid-operation: all state returns to reset values immediately, and the next `valid` is treated as a HUNT sample.

## Timing
- All outputs are registered.
- Reset values:
  - `locked`=0, `err`=0, `err_cnt`=0.
  - FSM=HUNT, `pred`=0, `run`=0, `miss`=0.
- Latency:
  - `err` and `err_cnt` update on the rising edge that samples the mismatching `d`. They are visible 1 cycle after the sample.
  - `locked` rises on the edge that samples the LOCK_CNT-th matching word. With `valid` held high, that is LOCK_CNT+1 valid samples after leaving reset.
  - `locked` falls on the edge that samples the LOSS_THRESH-th consecutive mismatch.
- Throughput: one word per cycle, with no backpressure.

## Structure
- Shared package `lfsr_pkg`:
  - function `lfsr_step(q, mask)` (parameterised by N), used by both `lfsr` and `lfsr_checker`.
  - FSM state enum `lfsr_chk_state_t` {HUNT, VERIFY, LOCKED}.
- Sub-module `sat_counter` (parameter W, with inc/clr inputs and the saturate rule above) implements `err_cnt`. Everything else is flat.

## Test plan
Settings: N=4, mask=0110, LOCK_CNT=3, LOSS_THRESH=4. Reference sequence from seed 0101: 0101, 1011, 0111, 1110, 1100, 1001, 0010, 0101, …

1. Clean lock:
   - Stimulus: feed the sequence from 0101 with `valid` high every cycle.
   - Required: `locked`=1 after the 4th sample (1110). `err` stays 0 over 50 cycles, and `err_cnt`=0.
2. Single error:
   - Stimulus: after lock, replace an expected 1100 with 1101. Resume the correct sequence (1001…).
   - Required: one `err` pulse, `err_cnt`=1, `locked` stays 1, and the following words match.
3. Loss of lock:
   - Stimulus: after lock, send 4 consecutive wrong words.
   - Required: `err_cnt`=4, `locked`=0 after the 4th. Resuming the correct sequence relocks after 4 samples.
4. Lockup word and gaps:
   - Stimulus: after reset, drive `d`=0000 for 5 cycles, then the sequence with `valid` toggling 1/0.
   - Required: no lock during the zeros, and lock after 4 valid samples regardless of gaps.
5. Counter rules:
   - Stimulus: with CNT_W=2, force 3 isolated errors while locked, then 1 more error.
   - Required: `err_cnt` saturates at 3.
   - Stimulus: assert `clr_cnt` in the same cycle as an error.
   - Required: `err_cnt`=1.
6. Asynchronous reset:
   - Stimulus: assert `rst` low mid-LOCKED, between clock edges.
   - Required: `locked`, `err` and `err_cnt` go to 0 immediately without waiting for `clk`.
